// File: rtl/fir_sym_decim.sv
// Symmetric FIR: delay line -> pair pre-add -> multiply -> sum -> output, with decimation.
// Define FIR_ROUND_SAT_EN for a round-half-away-from-zero shift with output saturation.
module fir_sym_decim #(
  parameter int DATA_W    = 12,
  parameter int NTAPS     = 20,
  parameter int COEF_W    = 13,
  parameter int DECIM     = 1,
  parameter int OUT_W     = 29,
  parameter int OUT_SHIFT = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic signed [DATA_W-1:0]        data_in,
  input  logic                            flush,
  input  logic                            coef_we,
  input  logic [$clog2(NTAPS/2)-1:0]      coef_addr,
  input  logic signed [COEF_W-1:0]        coef_wdata,
  output logic                            out_valid,
  output logic signed [OUT_W-1:0]         data_out
);
  localparam int NPAIR  = NTAPS / 2;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NPAIR);
  localparam int EXT_W  = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int STAGES = 4;

  logic [NTAPS-1:0][DATA_W-1:0] dly;
  logic [NPAIR-1:0][PROD_W-1:0] prod;
  logic [PH_W-1:0]              phase;
  logic [STAGES:0]              vld_pipe;
  logic signed [ACC_W-1:0]      acc_c, acc;
  logic signed [EXT_W-1:0]      acc_x;
  logic signed [OUT_W-1:0]      out_c;
  logic                         last;

  assign last      = (phase == PH_W'(DECIM - 1));
  assign out_valid = vld_pipe[STAGES];

  // Valid flags ride alongside: [0] delay line, [1] pre-add, [2] product, [3] sum, [4] output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dly      <= '0;
      phase    <= '0;
      vld_pipe <= '0;
      acc      <= '0;
    end else if (flush) begin
      dly      <= '0;
      phase    <= '0;
      vld_pipe <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid & last};
      acc      <= acc_c;
      if (in_valid) begin
        dly   <= {dly[NTAPS-2:0], data_in};
        phase <= last ? '0 : phase + 1'b1;
      end
    end

  // One lane per symmetric pair: coefficient, pre-add and product registers
  for (genvar k = 0; k < NPAIR; k++) begin : g_lane
    logic signed [COEF_W-1:0] coef;
    logic signed [DATA_W:0]   pre;
    logic signed [PROD_W-1:0] prod_r;

    always_ff @(posedge clk or posedge rst)
      if (rst) coef <= '0;
      else if (coef_we && int'(coef_addr) == k) coef <= coef_wdata;

    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        pre    <= '0;
        prod_r <= '0;
      end else if (flush) begin
        pre    <= '0;
        prod_r <= '0;
      end else begin
        pre    <= (DATA_W+1)'($signed(dly[k])) + (DATA_W+1)'($signed(dly[NTAPS-1-k]));
        prod_r <= PROD_W'(pre) * PROD_W'(coef);
      end

    assign prod[k] = prod_r;
  end

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < NPAIR; k++) acc_c = acc_c + ACC_W'($signed(prod[k]));
  end

  assign acc_x = EXT_W'(acc);

`ifdef FIR_ROUND_SAT_EN
  localparam int RS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] HALF  = (OUT_SHIFT > 0) ? (EXT_W'(1) << RS) : '0;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'({(OUT_W-1){1'b1}});
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] rnd, shr;
  logic                    neg_adj;

  // Negative values take half-minus-one so ties move away from zero under the floor shift
  assign neg_adj = (OUT_SHIFT > 0) && acc_x[EXT_W-1];
  assign rnd     = acc_x + HALF - EXT_W'(neg_adj);
  assign shr     = rnd >>> OUT_SHIFT;
  assign out_c   = (shr > MAX_V) ? OUT_W'(MAX_V) :
                   (shr < MIN_V) ? OUT_W'(MIN_V) : OUT_W'(shr);
`else
  assign out_c = OUT_W'(acc_x >>> OUT_SHIFT);
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) data_out <= '0;
    else if (!flush && vld_pipe[STAGES-1]) data_out <= out_c;

endmodule

// File: tb/tb_fir_sym_decim.sv
// Directed bench for fir_sym_decim; four parameterisations share one stimulus bus.
module tb_fir_sym_decim;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, coef_we = 1'b0;
  logic signed [11:0] data_in = '0;
  logic [3:0]         coef_addr = '0;
  logic signed [12:0] coef_wdata = '0;
  logic ov0, ov1, ov2, ov3;
  logic signed [28:0] do0, do1, do3;
  logic signed [15:0] do2;
  int n_tests = 0, n_fail = 0, cyc = 0;

  // scoreboard model: coefficient pairs, delay history (newest at [0]), DECIM=4 phase
  int hc[10] = '{default: 0};
  int xh[20] = '{default: 0};
  int ph4 = 0;
  longint e0_v[$], e1_v[$], m0_v[$], m1_v[$], m3_v[$];
  int     e0_c[$], e1_c[$], m0_c[$], m1_c[$];
  bit     e0_k[$], e1_k[$];

  fir_sym_decim u_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .out_valid(ov0), .data_out(do0));
  fir_sym_decim #(.DECIM(4)) u_dec (.clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(ov1), .data_out(do1));
  fir_sym_decim #(.OUT_W(16)) u_sat (.clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(ov2), .data_out(do2));
  fir_sym_decim #(.OUT_SHIFT(1)) u_sh (.clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(ov3), .data_out(do3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov0) begin m0_v.push_back(longint'(do0)); m0_c.push_back(cyc); end
    if (ov1) begin m1_v.push_back(longint'(do1)); m1_c.push_back(cyc); end
    if (ov3) m3_v.push_back(longint'(do3));
  end

  function automatic longint ref_y();
    longint s = 0;
    for (int k = 0; k < 20; k++) s += longint'(hc[(k < 10) ? k : 19 - k]) * longint'(xh[k]);
    return s;
  endfunction

  task automatic clear_q();
    e0_v.delete(); e0_c.delete(); e0_k.delete(); e1_v.delete(); e1_c.delete(); e1_k.delete();
    m0_v.delete(); m0_c.delete(); m1_v.delete(); m1_c.delete(); m3_v.delete();
  endtask

  // one clock of stimulus; the model is advanced for the edge just taken (edge index = cyc)
  task automatic step(input bit v, input int d, input bit fl = 0, input bit we = 0,
                      input int addr = 0, input int wd = 0);
    in_valid = v; data_in = 12'(d); flush = fl; coef_we = we;
    coef_addr = 4'(addr); coef_wdata = 13'(wd);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; coef_we = 1'b0;
    if (fl) begin
      for (int k = 0; k < 20; k++) xh[k] = 0;
      ph4 = 0;
      while (e0_c.size() > 0 && e0_c[$] >= cyc) begin e0_v.pop_back(); e0_c.pop_back(); e0_k.pop_back(); end
      while (e1_c.size() > 0 && e1_c[$] >= cyc) begin e1_v.pop_back(); e1_c.pop_back(); e1_k.pop_back(); end
    end else if (v) begin
      for (int k = 19; k > 0; k--) xh[k] = xh[k-1];
      xh[0] = d;
      e0_v.push_back(ref_y()); e0_c.push_back(cyc + 4); e0_k.push_back(1'b1);
      if (ph4 == 3) begin e1_v.push_back(ref_y()); e1_c.push_back(cyc + 4); e1_k.push_back(1'b1); end
      ph4 = (ph4 + 1) % 4;
    end
    if (we && addr < 10) begin
      hc[addr] = wd;
      foreach (e0_c[i]) if (e0_c[i] > cyc) e0_k[i] = 1'b0;
      foreach (e1_c[i]) if (e1_c[i] > cyc) e1_k[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ov0, ov1, ov2, ov3} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valid: out_valid=%b%b%b%b, want 0000", ov0, ov1, ov2, ov3);
    end
    n_tests++;
    if (do0 !== 29'sd0 || do2 !== 16'sd0) begin
      n_fail++; $display("FAIL reset_data: data_out=%0d/%0d, want 0/0", do0, do2);
    end
    rst = 1'b0;
    repeat (6) step(0, 0);
    n_tests++;
    if (m0_v.size() != 0 || m1_v.size() != 0) begin
      n_fail++; $display("FAIL reset_idle: %0d/%0d outputs, want 0/0", m0_v.size(), m1_v.size());
    end
  endtask

  task automatic test_impulse();
    int imp[25] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    int dexp[6] = '{4, 8, 9, 5, 1, 0};
    int c0, sh;
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, k, k + 1);
    clear_q();
    step(1, 1);
    c0 = cyc;
    repeat (24) step(1, 0);
    repeat (8) step(0, 0);
    n_tests++;
    if (m0_v.size() != 25) begin n_fail++; $display("FAIL impulse_count: got %0d, want 25", m0_v.size()); end
    for (int i = 0; i < 25 && i < m0_v.size(); i++) begin
      n_tests++;
      if (m0_v[i] != imp[i] || m0_c[i] != c0 + 4 + i) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got %0d @%0d, want %0d @%0d", i, m0_v[i], m0_c[i], imp[i], c0 + 4 + i);
      end
    end
    for (int i = 0; i < 25 && i < m3_v.size(); i++) begin
`ifdef FIR_ROUND_SAT_EN
      sh = (imp[i] + 1) / 2;
`else
      sh = imp[i] / 2;
`endif
      n_tests++;
      if (m3_v[i] != sh) begin n_fail++; $display("FAIL shift1[%0d]: got %0d, want %0d", i, m3_v[i], sh); end
    end
    n_tests++;
    if (m1_v.size() != 6) begin n_fail++; $display("FAIL impulse_dec_count: got %0d, want 6", m1_v.size()); end
    for (int i = 0; i < 6 && i < m1_v.size(); i++) begin
      n_tests++;
      if (m1_v[i] != dexp[i] || m1_c[i] != c0 + 4 * i + 7) begin
        n_fail++;
        $display("FAIL impulse_dec[%0d]: got %0d @%0d, want %0d @%0d", i, m1_v[i], m1_c[i], dexp[i], c0 + 4 * i + 7);
      end
    end
  endtask

  task automatic test_decim();
    step(0, 0, 1);
    clear_q();
    for (int i = 1; i <= 16; i++) begin
      step(1, i);
      if (i % 3 == 0) step(0, 0);
      if (i == 8) repeat (2) step(0, 0);
    end
    repeat (8) step(0, 0);
    n_tests++;
    if (m1_v.size() != 4) begin n_fail++; $display("FAIL decim_count: got %0d, want 4", m1_v.size()); end
    for (int i = 0; i < m1_v.size() && i < e1_v.size(); i++) begin
      n_tests++;
      if (m1_v[i] != e1_v[i] || m1_c[i] != e1_c[i]) begin
        n_fail++;
        $display("FAIL decim[%0d]: got %0d @%0d, want %0d @%0d", i, m1_v[i], m1_c[i], e1_v[i], e1_c[i]);
      end
    end
  endtask

  task automatic test_flush();
    longint hold = 0;
    clear_q();
    for (int i = 0; i < 10; i++) step(1, i * 37 - 150);
    foreach (e0_c[i]) if (e0_c[i] == cyc) hold = e0_v[i];
    step(1, 999, 1);
    n_tests++;
    if (ov0 !== 1'b0 || longint'(do0) != hold) begin
      n_fail++; $display("FAIL flush_hold: valid=%b data=%0d, want 0 %0d", ov0, do0, hold);
    end
    for (int i = 0; i < 20; i++) step(1, i * 53 - 500);
    repeat (8) step(0, 0);
    n_tests++;
    if (m0_v.size() != e0_v.size() || m1_v.size() != e1_v.size()) begin
      n_fail++;
      $display("FAIL flush_count: got %0d/%0d, want %0d/%0d", m0_v.size(), m1_v.size(), e0_v.size(), e1_v.size());
    end
    for (int i = 0; i < m0_v.size() && i < e0_v.size(); i++) begin
      n_tests++;
      if (m0_v[i] != e0_v[i] || m0_c[i] != e0_c[i]) begin
        n_fail++;
        $display("FAIL flush[%0d]: got %0d @%0d, want %0d @%0d", i, m0_v[i], m0_c[i], e0_v[i], e0_c[i]);
      end
    end
    for (int i = 0; i < m1_v.size() && i < e1_v.size(); i++) begin
      n_tests++;
      if (m1_v[i] != e1_v[i] || m1_c[i] != e1_c[i]) begin
        n_fail++;
        $display("FAIL flush_dec[%0d]: got %0d @%0d, want %0d @%0d", i, m1_v[i], m1_c[i], e1_v[i], e1_c[i]);
      end
    end
  endtask

  task automatic test_coef();
    clear_q();
    for (int i = 0; i < 6; i++) step(1, 300 - i * 90);
    step(1, 77, 0, 1, 3, -100);
    step(1, -77, 0, 1, 10, 1234);
    for (int i = 0; i < 20; i++) step(1, (i * 29) % 200 - 100);
    step(1, 55, 1, 1, 0, 7);
    for (int i = 0; i < 20; i++) step(1, 500 - i * 41);
    repeat (8) step(0, 0);
    n_tests++;
    if (m0_v.size() != e0_v.size()) begin
      n_fail++; $display("FAIL coef_count: got %0d, want %0d", m0_v.size(), e0_v.size());
    end
    for (int i = 0; i < m0_v.size() && i < e0_v.size(); i++)
      if (e0_k[i]) begin
        n_tests++;
        if (m0_v[i] != e0_v[i] || m0_c[i] != e0_c[i]) begin
          n_fail++;
          $display("FAIL coef[%0d]: got %0d @%0d, want %0d @%0d", i, m0_v[i], m0_c[i], e0_v[i], e0_c[i]);
        end
      end
  endtask

  task automatic test_sat();
    longint full = -167731200;
    logic [15:0] lo;
    logic signed [15:0] want2;
    lo = full[15:0];
`ifdef FIR_ROUND_SAT_EN
    want2 = -16'sd32768;
`else
    want2 = lo;
`endif
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, k, 4095);
    clear_q();
    repeat (24) step(1, -2048);
    repeat (6) step(0, 0);
    n_tests++;
    if (do2 !== want2) begin n_fail++; $display("FAIL sat16: got %0d, want %0d", do2, want2); end
    n_tests++;
    if (longint'(do0) != full) begin n_fail++; $display("FAIL sat29: got %0d, want %0d", do0, full); end
    n_tests++;
    if (longint'(do1) != full) begin n_fail++; $display("FAIL sat_dec: got %0d, want %0d", do1, full); end
    n_tests++;
    if (longint'(do3) != full / 2) begin n_fail++; $display("FAIL sat_shift: got %0d, want %0d", do3, full / 2); end
  endtask

  task automatic test_reset_mid();
    repeat (3) step(1, -2048);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ov0, ov1, ov2, ov3} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_valid: got %b%b%b%b, want 0000", ov0, ov1, ov2, ov3);
    end
    n_tests++;
    if (do0 !== 29'sd0 || do1 !== 29'sd0 || do2 !== 16'sd0) begin
      n_fail++; $display("FAIL rst_mid_data: got %0d/%0d/%0d, want 0/0/0", do0, do1, do2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) hc[k] = 0;
    for (int k = 0; k < 20; k++) xh[k] = 0;
    ph4 = 0;
    clear_q();
    repeat (8) step(1, 100);
    repeat (6) step(0, 0);
    n_tests++;
    if (m0_v.size() != 8 || m1_v.size() != 2) begin
      n_fail++; $display("FAIL rst_mid_count: got %0d/%0d, want 8/2", m0_v.size(), m1_v.size());
    end
    foreach (m0_v[i]) begin
      n_tests++;
      if (m0_v[i] != 0) begin n_fail++; $display("FAIL rst_mid_zero[%0d]: got %0d, want 0", i, m0_v[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_decim();
    test_flush();
    test_coef();
    test_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
